// File: rtl/vend_ctrl_if.sv
// Coin-in / vend-status bundle between the key front end, vend_ctrl and the display stage.
// vend_ctrl sits on the slave side: it consumes key_pulse and drives every status field.
interface vend_ctrl_if;
   logic [1:0] key_pulse;
   logic [3:0] credit;
   logic       dispense_on;
   logic       change_on;
   logic [3:0] change_amt;
   logic       coin_reject;
   logic       busy;
   logic [7:0] sold_cnt;

   modport master (
      output key_pulse,
      input  credit, dispense_on, change_on, change_amt, coin_reject, busy, sold_cnt
   );

   modport slave (
      input  key_pulse,
      output credit, dispense_on, change_on, change_amt, coin_reject, busy, sold_cnt
   );
endinterface

// File: rtl/vend_ctrl.sv
// Vending transaction FSM: coin credit, timed dispense/change, sold count; all outputs one cycle after the deciding edge.
// No backpressure: coins arriving while busy are dropped and flagged on coin_reject. Optional refund timeout: VEND_REFUND_TIMEOUT_EN.
module vend_ctrl #(
   parameter int PRICE          = 5,
   parameter int DISP_CYCLES    = 50_000_000,
   parameter int TIMEOUT_CYCLES = 500_000_000
) (
   input logic        CLK_50M,
   input logic        RST_N,
   vend_ctrl_if.slave vif
);
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

   localparam logic [4:0]  PRICE_U   = 5'(PRICE);
   localparam logic [31:0] DISP_LAST = 32'(DISP_CYCLES - 1);

   state_t      state, state_nxt;
   logic [31:0] phase;
   logic [3:0]  credit_q, credit_nxt;
   logic [3:0]  chg_q, chg_nxt;
   logic [7:0]  sold_q, sold_nxt;
   logic        disp_q, chgon_q, rej_q, busy_q;

   logic        coin;
   logic [4:0]  coin_val, sum;
   logic        pay_done, phase_done, timeout;

   assign coin       = |vif.key_pulse;
   assign coin_val   = {3'b000, vif.key_pulse[1], 1'b0} + {4'b0000, vif.key_pulse[0]};
   assign sum        = {1'b0, credit_q} + coin_val;
   assign pay_done   = (sum >= PRICE_U);
   assign phase_done = (phase == DISP_LAST);

`ifdef VEND_REFUND_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] idle_cnt;

   assign timeout = (state == S_COLLECT) && !coin && (idle_cnt == TO_LAST);

   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N)
         idle_cnt <= '0;
      else if (state == S_COLLECT && state_nxt == S_COLLECT && !coin)
         idle_cnt <= idle_cnt + 32'd1;
      else
         idle_cnt <= '0;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   // State register; the phase counter restarts on every state change.
   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         state <= S_IDLE;
         phase <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            phase <= '0;
         else if (state == S_VEND || state == S_CHANGE)
            phase <= phase + 32'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_COLLECT: begin
            if (coin)
               state_nxt = pay_done ? S_VEND : S_COLLECT;
            else if (timeout)
               state_nxt = S_CHANGE;
         end
         S_VEND:   if (phase_done) state_nxt = (chg_q != 4'd0) ? S_CHANGE : S_IDLE;
         S_CHANGE: if (phase_done) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      credit_nxt = credit_q;
      chg_nxt    = chg_q;
      sold_nxt   = sold_q;
      case (state)
         S_IDLE, S_COLLECT: begin
            if (coin) begin
               // A 3-unit coin on top of PRICE-1 can reach 16 at PRICE=14; hold credit at 15.
               credit_nxt = sum[4] ? 4'hF : sum[3:0];
               if (pay_done)
                  chg_nxt = 4'(sum - PRICE_U);
            end else if (timeout) begin
               chg_nxt = credit_q;
            end
         end
         S_VEND: begin
            if (phase_done) begin
               sold_nxt   = sold_q + 8'd1;
               credit_nxt = 4'd0;
            end
         end
         S_CHANGE: begin
            if (phase_done) begin
               chg_nxt    = 4'd0;
               credit_nxt = 4'd0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
         credit_q <= '0;
         chg_q    <= '0;
         sold_q   <= '0;
         disp_q   <= 1'b0;
         chgon_q  <= 1'b0;
         rej_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         credit_q <= credit_nxt;
         chg_q    <= chg_nxt;
         sold_q   <= sold_nxt;
         disp_q   <= (state_nxt == S_VEND);
         chgon_q  <= (state_nxt == S_CHANGE);
         busy_q   <= (state_nxt == S_VEND) || (state_nxt == S_CHANGE);
         rej_q    <= coin && (state == S_VEND || state == S_CHANGE);
      end
   end

   assign vif.credit      = credit_q;
   assign vif.change_amt  = chg_q;
   assign vif.sold_cnt    = sold_q;
   assign vif.dispense_on = disp_q;
   assign vif.change_on   = chgon_q;
   assign vif.coin_reject = rej_q;
   assign vif.busy        = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// Randomized and directed bench for vend_ctrl against a countdown-based transaction model.
module tb_vend_ctrl;
   localparam int PRICE = 5;
   localparam int DISP  = 4;
   localparam int TOUT  = 20;

   logic CLK_50M = 1'b0;
   logic RST_N   = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   vend_ctrl_if vif();

   vend_ctrl #(.PRICE(PRICE), .DISP_CYCLES(DISP), .TIMEOUT_CYCLES(TOUT)) dut (
      .CLK_50M (CLK_50M),
      .RST_N   (RST_N),
      .vif     (vif.slave)
   );

   always #10 CLK_50M = ~CLK_50M;

   // Model: credit, pending change, cycles left in dispense / change windows, idle time.
   int         m_credit, m_chg, m_vend_left, m_chg_left, m_idle;
   logic [7:0] m_sold;
   bit         m_rej;

   function automatic void model_reset();
      m_credit = 0; m_chg = 0; m_vend_left = 0; m_chg_left = 0; m_idle = 0;
      m_sold = 8'd0; m_rej = 1'b0;
   endfunction

   function automatic void model_step(input logic [1:0] kp);
      int cv;
      int nw;
      cv    = int'(kp[0]) + 2 * int'(kp[1]);
      m_rej = 1'b0;
      if (m_vend_left > 0) begin
         m_rej = (cv != 0);
         m_vend_left--;
         if (m_vend_left == 0) begin
            m_sold   = m_sold + 8'd1;
            m_credit = 0;
            if (m_chg > 0) m_chg_left = DISP;
         end
      end else if (m_chg_left > 0) begin
         m_rej = (cv != 0);
         m_chg_left--;
         if (m_chg_left == 0) begin
            m_chg    = 0;
            m_credit = 0;
         end
      end else if (cv != 0) begin
         nw     = m_credit + cv;
         m_idle = 0;
         m_credit = (nw > 15) ? 15 : nw;
         if (nw >= PRICE) begin
            m_chg       = nw - PRICE;
            m_vend_left = DISP;
         end
      end else if (m_credit > 0) begin
`ifdef VEND_REFUND_TIMEOUT_EN
         if (m_idle == TOUT - 1) begin
            m_chg      = m_credit;
            m_chg_left = DISP;
            m_idle     = 0;
         end else begin
            m_idle++;
         end
`endif
      end
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      check_val("credit",      32'(vif.credit),      32'(m_credit));
      check_val("change_amt",  32'(vif.change_amt),  32'(m_chg));
      check_val("dispense_on", 32'(vif.dispense_on), 32'(m_vend_left > 0));
      check_val("change_on",   32'(vif.change_on),   32'(m_chg_left > 0));
      check_val("busy",        32'(vif.busy),        32'((m_vend_left > 0) || (m_chg_left > 0)));
      check_val("coin_reject", 32'(vif.coin_reject), 32'(m_rej));
      check_val("sold_cnt",    32'(vif.sold_cnt),    32'(m_sold));
   endtask

   task automatic step(input logic [1:0] kp);
      vif.key_pulse = kp;
      @(posedge CLK_50M);
      model_step(kp);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00);
   endtask

   task automatic pulse_reset();
      RST_N = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge CLK_50M);
      RST_N = 1'b1;
   endtask

   initial begin
      vif.key_pulse = 2'b00;
      model_reset();
      #15;
      compare_all();
      @(negedge CLK_50M);
      RST_N = 1'b1;

      // Exact price: 2 + 2 + 1
      step(2'b10); step(2'b10); step(2'b01);
      idle(6);
      check_val("exact_sold", 32'(vif.sold_cnt), 32'd1);

      // Overpay: four half coins then a 1-yuan coin gives change of 1
      step(2'b01); step(2'b01); step(2'b01); step(2'b01); step(2'b10);
      check_val("ovp_chg", 32'(vif.change_amt), 32'd1);
      idle(10);

      // Double coins, then a coin while dispensing is rejected
      step(2'b11); step(2'b11);
      check_val("dbl_chg", 32'(vif.change_amt), 32'd1);
      step(2'b01);
      check_val("dbl_rej", 32'(vif.coin_reject), 32'd1);
      idle(10);

      // Asynchronous reset in the middle of a dispense
      step(2'b10); step(2'b10); step(2'b01); step(2'b00);
      #4;
      RST_N = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge CLK_50M);
      RST_N = 1'b1;
      idle(2);

      // Single coin then a long idle: held credit, or refund when the timeout is built in
      step(2'b10);
      idle(110);
`ifdef VEND_REFUND_TIMEOUT_EN
      check_val("to_credit", 32'(vif.credit), 32'd0);
`else
      check_val("hold_credit", 32'(vif.credit), 32'd2);
`endif

      // 256 exact-price sales wrap the sold counter back to zero
      pulse_reset();
      for (int s = 0; s < 256; s++) begin
         step(2'b10); step(2'b10); step(2'b01);
         idle(5);
      end
      check_val("sold_wrap", 32'(vif.sold_cnt), 32'd0);

      // Random coin traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0)
            step(2'($urandom_range(1, 3)));
         else
            step(2'b00);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Vending-machine transaction controller. Sits directly downstream of the key debounce stage.
- Consumes its 2-bit, one-clock "key pressed" pulses as coin-insert events and accumulates credit in half-yuan units.
- Drives a timed dispense indication and a timed change/refund indication.
- Exports credit and a sold-item count for the display stage.

Parameters:
- PRICE, 5, item price in half-yuan units (5 = 2.5 yuan); legal range 2..14
- DISP_CYCLES, 50_000_000, clock cycles that dispense_on and change_on stay asserted (1 s at 50 MHz)
- TIMEOUT_CYCLES, 500_000_000, idle cycles in COLLECT before automatic refund (10 s); used only with the optional feature

Ports:
- CLK_50M  input  1  system clock, 50 MHz
- RST_N  input  1  asynchronous active-low reset
- key_pulse  input  2  debounced one-cycle press pulses, active high; [0] = 0.5-yuan coin (+1 unit), [1] = 1-yuan coin (+2 units)
- credit  output  4  current accumulated credit, half-yuan units
- dispense_on  output  1  high while the item is being dispensed
- change_on  output  1  high while change/refund is being returned
- change_amt  output  4  units being returned; valid while change_on = 1
- coin_reject  output  1  one-cycle pulse: a coin arrived while busy and was ignored
- busy  output  1  high in VEND or CHANGE
- sold_cnt  output  8  items sold since reset; wraps 255 -> 0

Behaviour:
- Reset and output timing
  - All outputs registered.
  - Asynchronous reset forces state = IDLE and zeroes all outputs and internal counters.
  - Reset mid-transaction abandons it: credit is lost and no change is issued.
- Coin value: coin_val = key_pulse[0]*1 + key_pulse[1]*2. Both bits in the same cycle add 3.
- States: IDLE, COLLECT, VEND, CHANGE.
- IDLE
  - credit = 0.
  - On coin_val != 0: new = coin_val.
  - If new >= PRICE, go to VEND. Otherwise credit <= new and go to COLLECT.
- COLLECT
  - On coin_val != 0: new = credit + coin_val, computed at 5 bits.
  - If new >= PRICE: change_amt <= new - PRICE, credit <= new, go to VEND.
  - Otherwise credit <= new.
  - Latency: dispense_on rises the cycle after the qualifying pulse.
- VEND
  - dispense_on = 1 and busy = 1 for exactly DISP_CYCLES cycles, timed by a 32-bit phase counter cleared on entry.
  - On exit: sold_cnt increments and credit <= 0.
  - Next state is CHANGE if change_amt != 0, else IDLE.
- CHANGE
  - change_on = 1 and busy = 1 for exactly DISP_CYCLES cycles.
  - On exit: change_amt <= 0, credit <= 0, go to IDLE.
- coin_reject: any nonzero key_pulse in VEND or CHANGE produces a one-cycle coin_reject pulse. Credit is unchanged.
- Boundaries
  - Maximum credit is PRICE+1 (PRICE-1 plus a 2-unit coin), so change_amt from a sale is 0 or 1. A 3-unit double coin can give 2.
  - credit never exceeds 15.
  - sold_cnt wraps silently.
- key_pulse is assumed to be already synchronous to CLK_50M. No extra edge detection: each cycle high counts as one coin.

Optional Feature:
- Macro: VEND_REFUND_TIMEOUT_EN.
- Defined
  - A 32-bit idle counter runs in COLLECT and clears on every coin.
  - When it reaches TIMEOUT_CYCLES-1 with no coin: change_amt <= credit, go to CHANGE (full refund, no sale, sold_cnt unchanged).
  - A coin arriving in the same cycle as the timeout wins: it is added and the counter clears.
- Not defined
  - No idle counter. Credit in COLLECT is held indefinitely.
  - TIMEOUT_CYCLES is unused.

Test Plan (PRICE=5, DISP_CYCLES=4, TIMEOUT_CYCLES=20):
- Exact price: pulses [1],[1],[0] one cycle each -> credit 2,4, then VEND; dispense_on high 4 cycles; change_on never asserts; sold_cnt 0->1; credit returns to 0.
- Overpay: [0],[0],[0],[0],[1] -> credit 1,2,3,4, then new=6; dispense_on 4 cycles; then change_on 4 cycles with change_amt=1; then IDLE.
- Double coin and busy reject: key_pulse=2'b11 twice -> credit 3, then VEND with change_amt=1; a coin pulse during VEND -> coin_reject one cycle, credit unchanged.
- Reset mid-VEND: assert RST_N=0 asynchronously between clock edges -> all outputs 0 immediately; after release, state IDLE, sold_cnt 0.
- Wrap: complete 256 exact-price sales -> sold_cnt reads 0.
- With VEND_REFUND_TIMEOUT_EN: single [1] then nothing -> after 20 idle cycles, change_on for 4 cycles with change_amt=2; sold_cnt unchanged. Without the macro, credit holds at 2 for 100+ cycles.
